// File: rtl/mem_loader_if.sv
// Byte-stream and data-memory bus bundle for mem_loader.
// master = the loader (bus initiator), slave = byte source plus memory.
interface mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    modport master (
        input  rx_data, rx_valid, mem_out,
        output rx_ready, mem_address, mem_load, mem_in
    );

    modport slave (
        output rx_data, rx_valid, mem_out,
        input  rx_ready, mem_address, mem_load, mem_in
    );
endinterface

// File: rtl/mem_loader.sv
// Packs a big-endian byte stream into 16-bit words and writes them to consecutive RAM
// addresses. Define LOADER_VERIFY_EN to read back and compare every word after writing it.
module mem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_ADDR  = 16'h1FFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [15:0]  length_i,
    mem_loader_if.master bus,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [15:0]  words_written_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_HI, S_GET_LO, S_WRITE, S_VERIFY, S_DONE, S_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    // One extra bit so the address past 16'hFFFF can never alias to a write at 0.
    logic [16:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic        err_q, err_d;
    logic [15:0] maddr_q;
    logic [15:0] min_q;
    logic [15:0] cnt_inc;
    logic        addr_bad;

`ifdef LOADER_VERIFY_EN
    logic        vcnt_q, vcnt_d;
`else
    logic        unused_mem_out;
    assign unused_mem_out = ^bus.mem_out;
`endif

    assign cnt_inc  = cnt_q + 16'd1;
    assign addr_bad = addr_q > {1'b0, MAX_ADDR};

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        word_d          = word_q;
        err_d           = err_q;
`ifdef LOADER_VERIFY_EN
        vcnt_d          = vcnt_q;
`endif
        bus.rx_ready    = 1'b0;
        bus.mem_load    = 1'b0;
        bus.mem_address = maddr_q;
        bus.mem_in      = min_q;

        case (state_q)
            // ERR accepts a new start exactly like IDLE does
            S_IDLE, S_ERR: begin
                if (start_i) begin
                    cnt_d = 16'd0;
                    if (length_i != 16'd0) begin
                        len_d   = length_i;
                        addr_d  = {1'b0, BASE_ADDR};
                        err_d   = 1'b0;
                        state_d = S_GET_HI;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GET_HI: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    word_d[15:8] = bus.rx_data;
                    state_d      = S_GET_LO;
                end
            end
            S_GET_LO: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    word_d[7:0] = bus.rx_data;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (addr_bad) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    bus.mem_load    = 1'b1;
                    bus.mem_address = addr_q[15:0];
                    bus.mem_in      = word_q;
`ifdef LOADER_VERIFY_EN
                    vcnt_d  = 1'b0;
                    state_d = S_VERIFY;
`else
                    addr_d  = addr_q + 17'd1;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_GET_HI;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            // Two-cycle readback window; the compare happens on the second edge.
            S_VERIFY: begin
                bus.mem_address = addr_q[15:0];
                if (!vcnt_q) begin
                    vcnt_d = 1'b1;
                end else if (bus.mem_out != word_q) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    addr_d  = addr_q + 17'd1;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_GET_HI;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            addr_q  <= {1'b0, BASE_ADDR};
            cnt_q   <= 16'd0;
            word_q  <= 16'd0;
            err_q   <= 1'b0;
            maddr_q <= BASE_ADDR;
            min_q   <= 16'd0;
`ifdef LOADER_VERIFY_EN
            vcnt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
            maddr_q <= bus.mem_address;
            min_q   <= bus.mem_in;
`ifdef LOADER_VERIFY_EN
            vcnt_q  <= vcnt_d;
`endif
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign error_o         = err_q;
    assign words_written_o = cnt_q;

endmodule
